// File: rtl/alu_mux_arbiter_pkg.sv
// Shared types and select encodings for the ALU operand-path arbiter.
package alu_pkg;

    typedef enum logic [1:0] {
        IDLE,
        OWN_A,
        OWN_B
    } state_t;

    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

endpackage

// File: rtl/alu_mux_arbiter_if.sv
// Requester, output-stage and status signals of the ALU operand-path arbiter.
interface alu_mux_arbiter_if #(
    parameter int WIDTH = 8
);

    logic             a_valid;
    logic [WIDTH-1:0] a_data;
    logic             a_last;
    logic             a_ready;
    logic             b_valid;
    logic [WIDTH-1:0] b_data;
    logic             b_last;
    logic             b_ready;
    logic             sel;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_src;
    logic             out_last;
    logic             out_ready;
    logic             overrun;

    // Arbiter side: accepts requester beats and drives the output stage.
    modport slave (
        input  a_valid, a_data, a_last,
        input  b_valid, b_data, b_last,
        input  out_ready,
        output a_ready, b_ready, sel,
        output out_valid, out_data, out_src, out_last, overrun
    );

    // Requester / downstream side.
    modport master (
        output a_valid, a_data, a_last,
        output b_valid, b_data, b_last,
        output out_ready,
        input  a_ready, b_ready, sel,
        input  out_valid, out_data, out_src, out_last, overrun
    );

endinterface

// File: rtl/alu_mux_arbiter_twowaymux.sv
// Single-bit two-way mux: sel = 0 passes a, sel = 1 passes b.
module twowaymux (
    input  logic a,
    input  logic b,
    input  logic sel,
    output logic out
);

    assign out = sel ? b : a;

endmodule

// File: rtl/alu_mux_arbiter.sv
// Round-robin two-requester arbiter with packet hold, forced release after
// MAX_BEATS, and a one-entry registered output stage feeding the ALU.
module alu_mux_arbiter
    import alu_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int MAX_BEATS = 16
) (
    input  logic              clk,
    input  logic              rst,
    alu_mux_arbiter_if.slave  bus
);

    localparam int CW = $clog2(MAX_BEATS + 1);

    state_t           state;
    state_t           state_nx;
    logic             last_owner;
    logic             sel_q;
    logic             sel_c;
    logic [CW-1:0]    beat_cnt;
    logic [CW-1:0]    cnt_inc;
    logic             slot_free;
    logic             grant_a;
    logic             grant_b;
    logic             acc_a;
    logic             acc_b;
    logic             acc;
    logic             acc_last;
    logic             forced;
    logic [WIDTH-1:0] mux_data;

    assign slot_free = !bus.out_valid || bus.out_ready;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Output logic: grants, readies and mux select
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        sel_c   = sel_q;
        unique case (state)
            IDLE: begin
                grant_a = bus.a_valid && (!bus.b_valid || last_owner == SEL_B);
                grant_b = !grant_a && bus.b_valid;
            end
            OWN_A:   grant_a = 1'b1;
            OWN_B:   grant_b = 1'b1;
            default: ;
        endcase
        if (rst) begin
            grant_a = 1'b0;
            grant_b = 1'b0;
        end
        // A stalled output stage freezes the select along with everything else.
        if (slot_free) begin
            if (grant_a) begin
                sel_c = SEL_A;
            end else if (grant_b) begin
                sel_c = SEL_B;
            end
        end
        bus.a_ready = grant_a && slot_free;
        bus.b_ready = grant_b && slot_free;
    end

    assign bus.sel  = sel_c;
    assign acc_a    = bus.a_valid && bus.a_ready;
    assign acc_b    = bus.b_valid && bus.b_ready;
    assign acc      = acc_a || acc_b;
    assign acc_last = (sel_c == SEL_B) ? bus.b_last : bus.a_last;
    assign cnt_inc  = (state == IDLE) ? CW'(1) : beat_cnt + 1'b1;
    assign forced   = acc && !acc_last && (cnt_inc == CW'(MAX_BEATS));

    // Next-state logic
    always_comb begin
        state_nx = state;
        if (acc) begin
            if (acc_last || forced) begin
                state_nx = IDLE;
            end else if (acc_a) begin
                state_nx = OWN_A;
            end else begin
                state_nx = OWN_B;
            end
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_mux
        twowaymux u_mux (
            .a   (bus.a_data[i]),
            .b   (bus.b_data[i]),
            .sel (sel_c),
            .out (mux_data[i])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_owner    <= SEL_B;
            beat_cnt      <= '0;
            sel_q         <= SEL_A;
            bus.overrun   <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_src   <= 1'b0;
            bus.out_last  <= 1'b0;
        end else begin
            sel_q       <= sel_c;
            bus.overrun <= forced;
            if (acc) begin
                if (acc_last || forced) begin
                    beat_cnt   <= '0;
                    last_owner <= sel_c;
                end else begin
                    beat_cnt <= cnt_inc;
                end
                bus.out_valid <= 1'b1;
                bus.out_data  <= mux_data;
                bus.out_src   <= sel_c;
                bus.out_last  <= acc_last || forced;
            end else if (bus.out_ready) begin
                bus.out_valid <= 1'b0;
            end
        end
    end

endmodule
